// File: rtl/mem_port_arb.sv
// Single-port memory arbiter for the MIPS pipeline: serves the MEM-stage data
// access first, then the IF-stage fetch, stalling the pipeline until both complete.
module mem_port_arb #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        mem_byte,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        timeout_err
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    P_DATA  = 2'd0,
    P_FETCH = 2'd1,
    P_DONE  = 2'd2
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] mem_hold_q, mem_hold_d;
  logic [31:0] if_hold_q, if_hold_d;
  logic        terr_q, terr_d;

  logic dneed_s, data_ph_s, tgt_data_s, tgt_fetch_s, tgt_valid_s;
  logic ack_s, abort_s, done_s, stall_s;

  // Target selection, completion and stall decode
  always_comb begin
    dneed_s = mem_rd | mem_wr;
    case (phase_q)
      P_DATA:  data_ph_s = 1'b1;
      P_FETCH: data_ph_s = 1'b0;
      default: data_ph_s = 1'b1;   // P_DONE and unused codes recover as P_DATA
    endcase
    tgt_data_s  = data_ph_s & dneed_s;
    tgt_fetch_s = if_req & (~data_ph_s | ~dneed_s);
    tgt_valid_s = tgt_data_s | tgt_fetch_s;
    ack_s       = tgt_valid_s & bus_ack;
    abort_s     = tgt_valid_s & ~bus_ack & (wait_q == MAX_W);
    done_s      = ack_s | abort_s;
    // A finished data access still stalls while the fetch is outstanding
    stall_s     = tgt_valid_s & (~done_s | (tgt_data_s & if_req));
  end

  // Bus drive and read-data return
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    bus_be    = 4'h0;
    stall     = 1'b0;
    if (!rst_n) begin
      bus_req = 1'b0;
    end else if (tgt_data_s) begin
      bus_req   = 1'b1;
      bus_we    = mem_wr;
      bus_addr  = {mem_addr[31:2], 2'b00};
      bus_wdata = mem_byte ? {4{mem_wdata[7:0]}} : mem_wdata;
      bus_be    = mem_byte ? (4'b0001 << mem_addr[1:0]) : 4'hF;
      stall     = stall_s;
    end else if (tgt_fetch_s) begin
      bus_req  = 1'b1;
      bus_addr = {if_addr[31:2], 2'b00};
      bus_be   = 4'hF;
      stall    = stall_s;
    end else begin
      bus_req = 1'b0;
    end

    if (tgt_data_s && ack_s) begin
      mem_rdata = bus_rdata;
    end else if (tgt_data_s && abort_s) begin
      mem_rdata = 32'h0;
    end else begin
      mem_rdata = mem_hold_q;
    end
    if (tgt_fetch_s && ack_s) begin
      if_rdata = bus_rdata;
    end else if (tgt_fetch_s && abort_s) begin
      if_rdata = 32'h0;
    end else begin
      if_rdata = if_hold_q;
    end
    timeout_err = terr_q;
  end

  // Next-state logic for phase, wait counter, held data and error flag
  always_comb begin
    phase_d = data_ph_s ? P_DATA : P_FETCH;
    if (!stall_s) begin
      phase_d = P_DATA;
    end else if (tgt_data_s && done_s) begin
      phase_d = P_FETCH;
    end else begin
      phase_d = data_ph_s ? P_DATA : P_FETCH;
    end

    if (!tgt_valid_s || done_s) begin
      wait_d = 8'd0;
    end else begin
      wait_d = wait_q + 8'd1;
    end

    mem_hold_d = mem_hold_q;
    if_hold_d  = if_hold_q;
    if (ack_s) begin
      if (tgt_data_s) begin
        mem_hold_d = bus_rdata;
      end else begin
        if_hold_d = bus_rdata;
      end
    end else if (abort_s) begin
      if (tgt_data_s) begin
        mem_hold_d = 32'h0;
      end else begin
        if_hold_d = 32'h0;
      end
    end else begin
      mem_hold_d = mem_hold_q;
    end

    terr_d = terr_q | abort_s;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q    <= P_DATA;
      wait_q     <= 8'd0;
      mem_hold_q <= 32'h0;
      if_hold_q  <= 32'h0;
      terr_q     <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      wait_q     <= wait_d;
      mem_hold_q <= mem_hold_d;
      if_hold_q  <= if_hold_d;
      terr_q     <= terr_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Randomized self-checking bench for mem_port_arb: each pipeline cycle is
// expanded into its expected list of bus accesses and checked cycle by cycle.
module tb_mem_port_arb;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, mem_rd, mem_wr, mem_byte, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        stall, bus_req, bus_we, timeout_err;
  logic [3:0]  bus_be;

  int num_cmp = 0;
  int num_bad = 0;

  logic [31:0] m_hold [2];   // [0] = load data, [1] = fetch data
  logic        m_terr;

  mem_port_arb #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_cmp++;
    if (got !== exp) begin
      num_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic rd, input logic wr, input logic byt,
                       input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd);
    if_req = ir; mem_rd = rd; mem_wr = wr; mem_byte = byt;
    if_addr = ia; mem_addr = ma; mem_wdata = wd;
  endtask

  // One pipeline cycle: data access (if any) then fetch (if any), each with
  // its own memory latency; a latency above MAXW means the access is aborted.
  task automatic run_txn(input logic ir, input logic rd, input logic wr, input logic byt,
                         input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd,
                         input int lat_d, input int lat_f);
    bit active, last, ack, abrt;
    int lat, n;
    logic [31:0] e_addr, e_wd, rv, e_rd;
    logic [3:0]  e_be;
    if (!(ir || rd || wr)) begin
      @(negedge clk);
      drive(ir, rd, wr, byt, ia, ma, wd);
      bus_ack = 1'b0; bus_rdata = $urandom;
      #1;
      check_val("idle_req", 32'(bus_req), 32'd0);
      check_val("idle_stall", 32'(stall), 32'd0);
      check_val("idle_addr", bus_addr, 32'h0);
      check_val("idle_be", 32'(bus_be), 32'h0);
      @(posedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      active = (k == 0) ? (rd || wr) : ir;
      if (!active) continue;
      last = (k == 1) || !ir;
      lat  = (k == 0) ? lat_d : lat_f;
      n    = (lat > MAXW) ? MAXW + 1 : lat + 1;
      e_addr = (k == 0) ? {ma[31:2], 2'b00} : {ia[31:2], 2'b00};
      e_be   = (k == 0 && byt) ? (4'b0001 << ma[1:0]) : 4'hF;
      e_wd   = byt ? {4{wd[7:0]}} : wd;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        drive(ir, rd, wr, byt, ia, ma, wd);
        ack  = (c == lat);
        abrt = (lat > MAXW) && (c == MAXW);
        rv = $urandom;
        bus_ack = ack; bus_rdata = rv;
        #1;
        e_rd = ack ? rv : (abrt ? 32'h0 : m_hold[k]);
        check_val("req", 32'(bus_req), 32'd1);
        check_val("addr", bus_addr, e_addr);
        check_val("be", 32'(bus_be), 32'(e_be));
        check_val("we", 32'(bus_we), (k == 0) ? 32'(wr) : 32'd0);
        if (k == 0 && wr) check_val("wdata", bus_wdata, e_wd);
        check_val("stall", 32'(stall), (c == n - 1 && last) ? 32'd0 : 32'd1);
        check_val("terr", 32'(timeout_err), 32'(m_terr));
        if (k == 0) begin
          check_val("mem_rdata", mem_rdata, e_rd);
          check_val("if_hold", if_rdata, m_hold[1]);
        end else begin
          check_val("if_rdata", if_rdata, e_rd);
          check_val("mem_hold", mem_rdata, m_hold[0]);
        end
        @(posedge clk);
        if (ack) m_hold[k] = rv;
        if (abrt) begin
          m_hold[k] = 32'h0;
          m_terr = 1'b1;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0);
    bus_ack = 1'b0;
    #1;
    check_val("rst_req", 32'(bus_req), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_addr", bus_addr, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_val("rst_mem_rdata", mem_rdata, 32'h0);
    check_val("rst_if_rdata", if_rdata, 32'h0);
    check_val("rst_terr", 32'(timeout_err), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;
    m_hold[0] = 32'h0; m_hold[1] = 32'h0; m_terr = 1'b0;
  endtask

  initial begin
    int sel, ld, lf;
    rst_n = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    do_reset();

    // Fetch only, zero wait
    for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 32'h0, 0, 0);
    // Load + fetch
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h100, 32'h0, 0, 0);
    // Byte store to lane 3
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h203, 32'h12345678, 0, 0);
    // Wait states on data
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h48, 32'h300, 32'h0, 3, 0);
    // Timeout on data, then good accesses keep the sticky error
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h4C, 32'h304, 32'h0, 9, 0);
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 32'h308, 32'hCAFEF00D, 1, 1);
    run_txn(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Reset during a data wait
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h60, 32'h400, 32'h0);
    bus_ack = 1'b0;
    #1 check_val("mid_req", 32'(bus_req), 32'd1);
    @(posedge clk);
    do_reset();
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 32'h64, 32'h404, 32'h0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(5, 0);
      ld  = ($urandom_range(9, 0) == 0) ? 7 : $urandom_range(3, 0);
      lf  = ($urandom_range(9, 0) == 0) ? 7 : $urandom_range(3, 0);
      run_txn($urandom_range(3, 0) != 0, (sel == 2 || sel == 3 || sel == 5),
              (sel == 4 || sel == 5), 1'($urandom), $urandom, $urandom, $urandom, ld, lf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter and sequencer for the single-ported unified instruction/data memory of the MIPS pipeline. Each pipeline cycle, it serves the MEM-stage load/store first, then the IF-stage fetch. It drives a req/ack memory bus and holds the whole pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB) with `stall` until both accesses complete. A wait-state timeout turns a hung memory into a sticky error instead of a deadlock.

## Interface
- `MAX_WAIT`, 15: cycles an access may wait for `bus_ack` before abort (1..255)
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  synchronous active-low reset
- `if_req`  in  1  IF stage needs an instruction word this pipeline cycle
- `if_addr`  in  32  fetch address (word aligned)
- `if_rdata`  out  32  fetched instruction
- `mem_rd`  in  1  MEM stage load (`MEM_MemtoReg`)
- `mem_wr`  in  1  MEM stage store (`MEM_MemWrite`)
- `mem_byte`  in  1  byte access (`MEM_lb | MEM_lbu | MEM_sb`)
- `mem_addr`  in  32  data address (`MEM_ALUresult`)
- `mem_wdata`  in  32  store data (`MEM_busB`)
- `mem_rdata`  out  32  raw load word; sign/zero extension is done by the MEM stage
- `stall`  out  1  freeze all pipeline registers and the PC
- `bus_req`  out  1  memory request
- `bus_we`  out  1  write strobe
- `bus_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `bus_wdata`  out  32  write data
- `bus_be`  out  4  byte enables
- `bus_rdata`  in  32  read data, valid with `bus_ack`
- `bus_ack`  in  1  access complete; sampled in any cycle `bus_req`=1, including the first
- `timeout_err`  out  1  sticky: an access was aborted

## Operation
- **Data demand:** `dneed = mem_rd | mem_wr`.
  - `mem_rd` and `mem_wr` both high is illegal.
  - If it occurs, the access is treated as a write.
- **Phase register:** `phase ∈ {P_DATA, P_FETCH, P_DONE}`.
  - P_DATA: the data access has not been served.
  - P_FETCH: the data access is done or not needed; the fetch is pending.
  - P_DONE: both are served; only reachable while stall would otherwise persist, which does not occur, so it is kept as an illegal/recovery state that decodes to P_DATA.
- **Target selection (combinational):**
  - P_DATA with `dneed`: target is DATA.
  - P_DATA without `dneed`, or P_FETCH, with `if_req`: target is FETCH.
  - Otherwise: no target.
- **Bus drive:**
  - `bus_req` = target valid.
  - DATA target:
    - `bus_we` = `mem_wr`.
    - `bus_be` = `mem_byte ? (4'b0001 << mem_addr[1:0]) : 4'hF`.
    - `bus_wdata` = `mem_byte ? {4{mem_wdata[7:0]}} : mem_wdata`.
  - FETCH target: `bus_we`=0, `bus_be`=4'hF.
  - No target: `bus_addr`, `bus_wdata` and `bus_be` are 0.
- **Stall:** `stall` = target valid and no completion this cycle.
  - A completion is `bus_ack`, or an abort by timeout.
  - A DATA completion with `if_req` high keeps `stall`=1, because FETCH is still pending.
- **Phase update on completion:**
  - DATA completion: phase goes to P_FETCH.
  - FETCH completion: phase goes to P_DATA.
  - When `stall`=0 (pipeline advances), phase goes to P_DATA.
- **Read data:**
  - `mem_rdata`/`if_rdata` pass `bus_rdata` through combinationally in the cycle of their own ack.
  - Otherwise they show a register holding the last acked value of that kind.
- **Wait counter (8 bit):**
  - Increments each cycle `bus_req`=1 without `bus_ack`.
  - Clears on completion and when there is no target.
- **Abort:** when the counter equals `MAX_WAIT` and there is no ack:
  - The access is completed as an abort.
  - Returned data is 32'h0 (the held register loads 0).
  - `timeout_err` sets and stays set until reset.

## Timing
- **Reset (`rst_n`=0 at a rising edge):**
  - phase = P_DATA, counter = 0, held `mem_rdata`/`if_rdata` = 0, `timeout_err` = 0.
  - Bus outputs are forced to 0 and `stall`=0 for as long as `rst_n`=0.
- **Zero-wait memory:**
  - Fetch only: `stall`=0; the pipeline advances every cycle.
  - Load/store plus fetch: 2 cycles. Cycle 1 is DATA with `stall`=1; cycle 2 is FETCH with `stall`=0.
- **Wait states:** each wait cycle adds one `stall` cycle.
- **Abort cycle:** `stall`=0 in the abort cycle if that was the last pending access.
- **Inputs during stall:** `if_*`/`mem_*` are stable, because the pipeline is frozen. The block does not latch them.
- **Reset mid-access:**
  - `bus_req` drops at once.
  - An in-flight access is abandoned.
  - The memory must tolerate a dropped request.

## Test plan
- **Fetch only:** `if_req`=1, `dneed`=0, ack same cycle → `stall` never 1; `if_rdata`=`bus_rdata`; one fetch per clock.
- **Load + fetch:** `mem_rd`=1, `mem_addr`=0x100, `if_addr`=0x40, ack same cycle.
  - Cycle 1: `bus_addr`=0x100, `stall`=1.
  - Cycle 2: `bus_addr`=0x40, `stall`=0.
  - `mem_rdata` holds the cycle-1 data.
- **Byte store:** `sb`, `mem_addr`=0x203, `mem_wdata`=0x12345678 → `bus_be`=4'b1000, `bus_wdata`=0x78787878, `bus_addr`=0x200, `bus_we`=1.
- **Wait states:** ack delayed 3 cycles on DATA, immediate on FETCH → `stall`=1 for exactly 4 cycles, then 0.
- **Timeout:** `MAX_WAIT`=4, no ack on DATA → abort on the 5th request cycle; `mem_rdata`=0; `timeout_err`=1 persists through later good accesses until `rst_n`=0.
- **Reset mid-access:** `rst_n`=0 during a DATA wait → next cycle `bus_req`=0, `stall`=0, phase P_DATA; the first post-reset access is DATA.
